// File: rtl/div_unit.sv
// Multi-cycle restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One quotient bit per CALC cycle; special results bypass CALC straight into FIX.
module div_unit #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Start,
  input  logic [n-1:0] DIV_A,
  input  logic [n-1:0] DIV_B,
  input  logic [1:0]   DIV_Sel,
  output logic         Busy,
  output logic         Done,
  output logic [n-1:0] DIV_out
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t        r_state;
  logic [n-1:0]  r_quo;
  logic [n-1:0]  r_rem;
  logic [n-1:0]  r_div;
  logic [CW-1:0] r_cnt;
  logic          r_sel_rem;
  logic          r_q_neg;
  logic          r_r_neg;
  logic          r_busy;
  logic          r_done;
  logic [n-1:0]  r_out;

  // Operand conditioning at issue time
  logic          w_signed;
  logic          w_a_neg;
  logic          w_b_neg;
  logic [n-1:0]  w_a_abs;
  logic [n-1:0]  w_b_abs;
  logic [n-1:0]  w_min_neg;
  logic          w_dz;
  logic          w_ovf;

  assign w_signed  = ~DIV_Sel[0];
  assign w_a_neg   = w_signed & DIV_A[n-1];
  assign w_b_neg   = w_signed & DIV_B[n-1];
  assign w_a_abs   = w_a_neg ? -DIV_A : DIV_A;
  assign w_b_abs   = w_b_neg ? -DIV_B : DIV_B;
  assign w_min_neg = {1'b1, {(n-1){1'b0}}};
  assign w_dz      = (DIV_B == '0);
  assign w_ovf     = w_signed & (DIV_A == w_min_neg) & (DIV_B == '1);

  // Trial subtract is one bit wider than the shifted remainder so the borrow is the compare
  logic [n:0]    w_rem_sh;
  logic [n+1:0]  w_sub;
  logic          w_ge;

  assign w_rem_sh = {r_rem, r_quo[n-1]};
  assign w_sub    = {1'b0, w_rem_sh} - {2'b00, r_div};
  assign w_ge     = ~w_sub[n+1];

  logic [n-1:0]  w_q_fix;
  logic [n-1:0]  w_r_fix;
  logic [n-1:0]  w_res;

  assign w_q_fix = r_q_neg ? -r_quo : r_quo;
  assign w_r_fix = r_r_neg ? -r_rem : r_rem;
  assign w_res   = r_sel_rem ? w_r_fix : w_q_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_quo     <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_sel_rem <= 1'b0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_out     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_sel_rem <= DIV_Sel[1];
            r_busy    <= 1'b1;
            r_div     <= w_b_abs;
            r_cnt     <= '0;
            if (w_dz) begin
              r_quo   <= '1;
              r_rem   <= DIV_A;
              r_q_neg <= 1'b0;
              r_r_neg <= 1'b0;
              r_state <= S_FIX;
            end else if (w_ovf) begin
              r_quo   <= DIV_A;
              r_rem   <= '0;
              r_q_neg <= 1'b0;
              r_r_neg <= 1'b0;
              r_state <= S_FIX;
            end else begin
              r_quo   <= w_a_abs;
              r_rem   <= '0;
              r_q_neg <= w_a_neg ^ w_b_neg;
              r_r_neg <= w_a_neg;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_quo <= {r_quo[n-2:0], w_ge};
          r_rem <= w_ge ? w_sub[n-1:0] : w_rem_sh[n-1:0];
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(n-1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_out   <= w_res;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy    = r_busy;
  assign Done    = r_done;
  assign DIV_out = r_out;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus handshake and reset sequences.
`timescale 1ns/1ps
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        Start;
  logic [31:0] DIV_A;
  logic [31:0] DIV_B;
  logic [1:0]  DIV_Sel;
  logic        Busy;
  logic        Done;
  logic [31:0] DIV_out;

  int n_checks = 0;
  int n_errors = 0;

  div_unit #(.n(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .Start   (Start),
    .DIV_A   (DIV_A),
    .DIV_B   (DIV_B),
    .DIV_Sel (DIV_Sel),
    .Busy    (Busy),
    .Done    (Done),
    .DIV_out (DIV_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sel;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents an op on the falling edge; returns #1 after the Start edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel);
    @(negedge clk);
    DIV_A   = a;
    DIV_B   = b;
    DIV_Sel = sel;
    Start   = 1'b1;
    @(posedge clk);
    #1;
    Start   = 1'b0;
  endtask

  // Counts edges until Done is seen; bounded so a dead DUT cannot hang the run.
  task automatic wait_done(output int lat, output logic [31:0] res);
    lat = 0;
    while (!Done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = DIV_out;
  endtask

  int          lat;
  logic [31:0] res;
  logic [31:0] held;
  int          spurious;

  initial begin
    vecs[0]  = '{32'd100,      32'd7,          2'b00, 32'h0000000E, 33};
    vecs[1]  = '{32'd100,      32'd7,          2'b10, 32'h00000002, 33};
    vecs[2]  = '{32'hFFFFFF9C, 32'd7,          2'b00, 32'hFFFFFFF2, 33};
    vecs[3]  = '{32'hFFFFFF9C, 32'd7,          2'b10, 32'hFFFFFFFE, 33};
    vecs[4]  = '{32'd100,      32'hFFFFFFF9,   2'b00, 32'hFFFFFFF2, 33};
    vecs[5]  = '{32'd100,      32'hFFFFFFF9,   2'b10, 32'h00000002, 33};
    vecs[6]  = '{32'hFFFFFFFF, 32'd2,          2'b01, 32'h7FFFFFFF, 33};
    vecs[7]  = '{32'hFFFFFFFF, 32'd2,          2'b11, 32'h00000001, 33};
    vecs[8]  = '{32'hFFFFFFFF, 32'd2,          2'b00, 32'h00000000, 33};
    vecs[9]  = '{32'hFFFFFFFF, 32'd2,          2'b10, 32'hFFFFFFFF, 33};
    vecs[10] = '{32'd5,        32'd0,          2'b01, 32'hFFFFFFFF, 1};
    vecs[11] = '{32'd5,        32'd0,          2'b10, 32'h00000005, 1};
    vecs[12] = '{32'd5,        32'd0,          2'b00, 32'hFFFFFFFF, 1};
    vecs[13] = '{32'd5,        32'd0,          2'b11, 32'h00000005, 1};
    vecs[14] = '{32'h80000000, 32'hFFFFFFFF,   2'b00, 32'h80000000, 1};
    vecs[15] = '{32'h80000000, 32'hFFFFFFFF,   2'b10, 32'h00000000, 1};
    vecs[16] = '{32'h80000000, 32'hFFFFFFFF,   2'b11, 32'h80000000, 33};

    rst     = 1'b1;
    Start   = 1'b0;
    DIV_A   = '0;
    DIV_B   = '0;
    DIV_Sel = 2'b00;
    #1;
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    chk("reset_done", {31'd0, Done}, 32'd0);
    chk("reset_out",  DIV_out,       32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sel);
      chk($sformatf("v%0d_busy", i), {31'd0, Busy}, 32'd1);
      wait_done(lat, res);
      $display("vec %0d sel=%b a=%h b=%h -> out=%h lat=%0d", i, vecs[i].sel, vecs[i].a, vecs[i].b, res, lat);
      chk($sformatf("v%0d_result", i), res, vecs[i].exp);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy_at_done", i), {31'd0, Busy}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), {31'd0, Done}, 32'd0);
      chk($sformatf("v%0d_out_hold", i), DIV_out, vecs[i].exp);
    end

    // Start while busy must be ignored
    start_op(32'd100, 32'd7, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    DIV_A = 32'd1;
    DIV_B = 32'd1;
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    wait_done(lat, res);
    lat = lat + 4;
    $display("busy-start: out=%h lat=%0d", res, lat);
    chk("busy_start_result",  res, 32'd14);
    chk("busy_start_latency", lat, 33);

    // Back-to-back: Start presented inside the Done cycle
    start_op(32'd9, 32'd3, 2'b01);
    chk("b2b_done_clear", {31'd0, Done}, 32'd0);
    chk("b2b_busy",       {31'd0, Busy}, 32'd1);
    wait_done(lat, res);
    $display("back-to-back: out=%h lat=%0d", res, lat);
    chk("b2b_result",  res, 32'd3);
    chk("b2b_latency", lat, 33);

    // Reset mid-operation aborts at once and suppresses Done
    start_op(32'd100, 32'd7, 2'b00);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    $display("reset mid-op: busy=%b done=%b out=%h", Busy, Done, DIV_out);
    chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
    chk("rst_mid_done", {31'd0, Done}, 32'd0);
    chk("rst_mid_out",  DIV_out,       32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (Done || Busy) spurious++;
    end
    chk("rst_no_done", spurious, 0);

    start_op(32'd9, 32'd3, 2'b01);
    wait_done(lat, res);
    $display("after reset: out=%h lat=%0d", res, lat);
    chk("post_rst_result",  res, 32'd3);
    chk("post_rst_latency", lat, 33);
    held = DIV_out;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_hold", DIV_out, 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative integer divider that performs RISC-V M-extension DIV, DIVU, REM and REMU.
- It is the inverse counterpart to the multiply/arith path: the combinational ALU handles single-cycle ops, and this block handles division in the execute stage.
- The control unit issues a Start pulse with operands and opcode, stalls the pipeline while Busy is high, and captures DIV_out on the Done pulse.
- Uses a restoring shift-subtract algorithm that produces one quotient bit per cycle.

Parameters:
- n, 32, operand/result width in bits (n >= 2).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only when the block is idle.
- DIV_A  input  n  dividend, sampled with Start.
- DIV_B  input  n  divisor, sampled with Start.
- DIV_Sel  input  2  operation: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse; DIV_out is valid from this cycle on.
- DIV_out  output  n  registered result; holds its value until the next Done.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; Busy = 0; Done = 0; DIV_out = 0.
  - Internal quotient, remainder, divisor and counter registers clear to 0.
- States: IDLE, CALC, FIX.
- Busy = (state != IDLE). Busy is a registered output, not derived from Start.
- IDLE:
  - On an edge where Start = 1, latch DIV_A, DIV_B and DIV_Sel.
  - Signed ops (00, 10): latch the absolute values, plus q_neg = sign(A) xor sign(B) and r_neg = sign(A).
  - Unsigned ops: take operands as-is; q_neg = r_neg = 0.
  - Divide by zero or signed overflow (see below): go directly to FIX with the special result preloaded.
  - Otherwise: go to CALC, counter = 0, remainder = 0.
- CALC, one iteration per edge:
  - {rem, quo} shifts left by 1.
  - If rem >= divisor: rem = rem - divisor and set the quotient LSB to 1.
  - The comparison uses an (n+1)-bit subtract so there is no wrap.
  - After iteration n (counter == n-1), go to FIX.
- FIX, one edge:
  - DIV_out = quotient for 00/01, or remainder for 10/11.
  - Negate the quotient if q_neg; negate the remainder if r_neg.
  - Done = 1 for exactly this one cycle; state returns to IDLE.
- Latency, with the Start edge as edge k:
  - Normal operation: Done is high in the cycle after edge k+n+1 (33 cycles for n = 32).
  - Special case: Done is high in the cycle after edge k+1.
- Special results (RISC-V defined, no trap):
  - Divide by zero (DIV_B == 0): DIV/DIVU return all ones; REM/REMU return DIV_A.
  - Signed overflow (DIV or REM with DIV_A = 1 followed by n-1 zeros, and DIV_B = all ones): DIV returns DIV_A; REM returns 0.
- Start handling:
  - Start while Busy = 1 is ignored; the latched operands are unaffected.
  - Start in the Done cycle is accepted, since state is already IDLE. This allows back-to-back operation.
- Reset mid-operation aborts immediately. No Done is issued and DIV_out reads 0.
- Done never asserts without a preceding accepted Start.
- DIV_out changes only on a Done cycle or on reset.

Test Plan:
- DIV_Sel = 00, A = 100, B = 7, Start for 1 cycle: Busy stays high for 33 cycles, then Done pulses once with DIV_out = 14 (0x0000000E). Repeat with Sel = 10: DIV_out = 2.
- Signed: A = -100 (0xFFFFFF9C), B = 7. DIV gives 0xFFFFFFF2 (-14). REM gives 0xFFFFFFFE (-2). Also A = 100, B = -7: DIV gives -14 and REM gives +2.
- Unsigned: DIVU with A = 0xFFFFFFFF, B = 2 gives 0x7FFFFFFF. REMU with the same operands gives 1. The signed DIV of the same operands gives 0 (-1/2 truncates to 0).
- Specials, each with Done one cycle after the Start edge:
  - DIVU 5/0 gives 0xFFFFFFFF.
  - REM 5/0 gives 5.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000.
  - REM with the same operands gives 0.
- Handshake: during a busy cycle, pulse Start with A = 1, B = 1. The result stays that of the original op (100/7 = 14). A new Start asserted in the Done cycle is accepted, and its Done follows 33 cycles later.
- Reset: assert rst 10 cycles into a DIV. Busy, Done and DIV_out drop to 0 immediately, and no Done follows. After release, 9/3 DIVU returns 3 with normal latency.
